// File: rtl/arb_mux_if.sv
// rtl/arb_mux_if.sv - handshake bundle between producers, arb_mux and its consumer
interface arb_mux_if #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4
);
   localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_ready;
   logic                      out_valid;
   logic [WIDTH-1:0]          out_data;
   logic [SEL_W-1:0]          out_sel;
   logic                      out_ready;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/arb_mux.sv
// rtl/arb_mux.sv - N-channel registered mux with round-robin arbitration
// Define ARB_MUX_FIXED_PRIO_EN for fixed lowest-index-first priority instead.
module arb_mux #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4
) (
   input  logic     clk,
   input  logic     rst,
   arb_mux_if.slave bus
);
   localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic             load_en;
   logic             grant_valid;
   logic [SEL_W-1:0] grant;
   logic [SEL_W-1:0] lo_idx;
   logic [WIDTH-1:0] grant_data;
   logic             xfer;
   logic [SEL_W-1:0] ptr;

   assign load_en = !bus.out_valid || bus.out_ready;
   assign xfer    = grant_valid && load_en;

   always_comb begin
      grant_valid = 1'b0;
      lo_idx      = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (bus.in_valid[i] && !grant_valid) begin
            grant_valid = 1'b1;
            lo_idx      = SEL_W'(i);
         end
      end
   end

`ifdef ARB_MUX_FIXED_PRIO_EN
   assign ptr   = '0;
   assign grant = lo_idx;
`else
   logic             hi_found;
   logic [SEL_W-1:0] hi_idx;
   logic [SEL_W-1:0] next_ptr;

   // First request at or above ptr wins; otherwise wrap to the lowest request.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (bus.in_valid[i] && !hi_found && (SEL_W'(i) >= ptr)) begin
            hi_found = 1'b1;
            hi_idx   = SEL_W'(i);
         end
      end
   end

   assign grant    = hi_found ? hi_idx : lo_idx;
   assign next_ptr = (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (xfer) begin
         ptr <= next_ptr;
      end
   end
`endif

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (grant == SEL_W'(i)) begin
            grant_data = bus.in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      bus.in_ready = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         bus.in_ready[i] = !rst && xfer && (grant == SEL_W'(i));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_sel   <= '0;
      end else if (xfer) begin
         bus.out_valid <= 1'b1;
         bus.out_data  <= grant_data;
         bus.out_sel   <= grant;
      end else if (bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule
